// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;

    localparam int WDOG_W = 16;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_DMEM  = 3'd1,
        CAUSE_EX    = 3'd2,
        CAUSE_HZD   = 3'd3,
        CAUSE_FETCH = 3'd4,
        CAUSE_KILL  = 3'd5
    } stall_cause_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central stall/flush sequencer with redirect kill tracking,
// performance counters and a frozen-PC watchdog
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 256,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hzd_stall,
    input  logic             imem_valid,
    input  logic             dmem_busy,
    input  logic             ex_busy,
    input  logic             redirect_req,
    input  logic [31:0]      redirect_target,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             wdog_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_nxt;
    stall_cause_t        w_cause;
    logic                w_take_redir;
    logic [WDOG_W-1:0]   w_wdog_cnt;
    logic                r_wdog_err;

    // Redirect sits between the hazard stall and the fetch wait in priority.
    always_comb begin
        w_cause      = CAUSE_NONE;
        w_take_redir = 1'b0;
        if (dmem_busy)                         w_cause = CAUSE_DMEM;
        else if (ex_busy)                      w_cause = CAUSE_EX;
        else if (hzd_stall)                    w_cause = CAUSE_HZD;
        else if (redirect_req)                 w_take_redir = 1'b1;
        else if (r_state == ST_RUN && !imem_valid) w_cause = CAUSE_FETCH;
        else if (r_state == ST_KILL)           w_cause = CAUSE_KILL;
    end

    always_comb begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b0;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (w_cause)
                CAUSE_DMEM: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                end
                CAUSE_EX: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                end
                CAUSE_HZD: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                CAUSE_FETCH, CAUSE_KILL: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
            if (w_take_redir) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    assign redirect_pc = redirect_target;

    // Any imem_valid seen in KILL is the stale response, whatever else wins the cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_take_redir) begin
            w_state_nxt = imem_valid ? ST_RUN : ST_KILL;
        end else if (r_state == ST_KILL && imem_valid) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wdog_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!pc_en && (w_wdog_cnt == WDOG_W'(WDOG_LIMIT - 1))) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_en),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_take_redir),
        .clr   (1'b0),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(WDOG_W)) u_wdog_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_en),
        .clr   (pc_en),
        .count (w_wdog_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with directed vectors
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hzd_stall = 1'b0;
    logic        imem_valid = 1'b0;
    logic        dmem_busy = 1'b0;
    logic        ex_busy = 1'b0;
    logic        redirect_req = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [31:0] redirect_pc;
    logic        wdog_err;
    logic [3:0]  stall_cnt, flush_cnt;

    pipeline_ctrl #(.WDOG_LIMIT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hzd_stall       (hzd_stall),
        .imem_valid      (imem_valid),
        .dmem_busy       (dmem_busy),
        .ex_busy         (ex_busy),
        .redirect_req    (redirect_req),
        .redirect_target (redirect_target),
        .pc_en           (pc_en),
        .pc_redirect     (pc_redirect),
        .redirect_pc     (redirect_pc),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .wdog_err        (wdog_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
    localparam logic [8:0] C_RST  = 9'b0_0_000_1111;
    localparam logic [8:0] C_NORM = 9'b1_0_111_0000;
    localparam logic [8:0] C_HZD  = 9'b0_0_011_0100;
    localparam logic [8:0] C_DMEM = 9'b0_0_000_0001;
    localparam logic [8:0] C_EX   = 9'b0_0_001_0010;
    localparam logic [8:0] C_REDR = 9'b1_1_111_1000;
    localparam logic [8:0] C_FTCH = 9'b0_0_111_1000;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [31:0] rpc;
        logic [3:0]  scnt;
        logic [3:0]  fcnt;
        logic        wdog;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic vec(input string name, input logic rst, input logic hzd, input logic iv,
                       input logic dm, input logic ex, input logic rr, input logic [31:0] tgt,
                       input logic [8:0] ctl, input int s, input int f, input logic w);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; hzd_stall = hzd; imem_valid = iv; dmem_busy = dm;
        ex_busy = ex; redirect_req = rr; redirect_target = tgt;
        e.name = name; e.ctl = ctl; e.rpc = tgt;
        e.scnt = 4'(s); e.fcnt = 4'(f); e.wdog = w;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [8:0] act;
            e = sb.pop_front();
            act = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
            end
            checks++;
            if (redirect_pc !== e.rpc) begin
                errors++;
                $display("FAIL %s redirect_pc: got %h expected %h", e.name, redirect_pc, e.rpc);
            end
            checks++;
            if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
                errors++;
                $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                         e.name, stall_cnt, flush_cnt, e.scnt, e.fcnt);
            end
            checks++;
            if (wdog_err !== e.wdog) begin
                errors++;
                $display("FAIL %s wdog_err: got %b expected %b", e.name, wdog_err, e.wdog);
            end
        end
    end

    initial begin
        //   name          rst hzd iv dm ex rr tgt         ctl     s   f  w
        vec("reset",       0,  0,  1, 0, 0, 0, 32'h0,      C_RST,  0,  0, 0);
        vec("run0",        1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 0,  0, 0);
        vec("run1",        1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 0,  0, 0);
        vec("hzd_redir",   1,  1,  1, 0, 0, 1, 32'h40,     C_HZD,  0,  0, 0);
        vec("after_hzd",   1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 1,  0, 0);
        vec("dmem0",       1,  1,  1, 1, 1, 0, 32'h0,      C_DMEM, 1,  0, 0);
        vec("dmem1",       1,  1,  1, 1, 1, 0, 32'h0,      C_DMEM, 2,  0, 0);
        vec("dmem2",       1,  1,  1, 1, 1, 0, 32'h0,      C_DMEM, 3,  0, 0);
        vec("after_dmem",  1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 4,  0, 0);
        vec("redir_kill",  1,  0,  0, 0, 0, 1, 32'h80,     C_REDR, 4,  0, 0);
        vec("kill_wait",   1,  0,  0, 0, 0, 0, 32'h0,      C_FTCH, 4,  1, 0);
        vec("kill_drop",   1,  0,  1, 0, 0, 0, 32'h0,      C_FTCH, 5,  1, 0);
        vec("back_run",    1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 6,  1, 0);
        vec("fetch_wait",  1,  0,  0, 0, 0, 0, 32'h0,      C_FTCH, 6,  1, 0);
        vec("fetch_done",  1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 7,  1, 0);
        vec("redir_run",   1,  0,  1, 0, 0, 1, 32'h100,    C_REDR, 7,  1, 0);
        vec("no_kill",     1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 7,  2, 0);
        vec("ex0",         1,  0,  1, 0, 1, 0, 32'h0,      C_EX,   7,  2, 0);
        vec("ex1",         1,  0,  1, 0, 1, 0, 32'h0,      C_EX,   8,  2, 0);
        vec("ex2",         1,  0,  1, 0, 1, 0, 32'h0,      C_EX,   9,  2, 0);
        vec("ex3",         1,  0,  1, 0, 1, 0, 32'h0,      C_EX,   10, 2, 0);
        vec("ex4_wdog",    1,  0,  1, 0, 1, 0, 32'h0,      C_EX,   11, 2, 1);
        vec("wdog_hold0",  1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 12, 2, 1);
        vec("wdog_hold1",  1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 12, 2, 1);
        vec("sat0",        1,  1,  1, 0, 0, 0, 32'h0,      C_HZD,  12, 2, 1);
        vec("sat1",        1,  1,  1, 0, 0, 0, 32'h0,      C_HZD,  13, 2, 1);
        vec("sat2",        1,  1,  1, 0, 0, 0, 32'h0,      C_HZD,  14, 2, 1);
        vec("sat3",        1,  1,  1, 0, 0, 0, 32'h0,      C_HZD,  15, 2, 1);
        vec("sat_hold",    1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 15, 2, 1);
        vec("redir_kill2", 1,  0,  0, 0, 0, 1, 32'h200,    C_REDR, 15, 2, 1);
        vec("kill_wait2",  1,  0,  0, 0, 0, 0, 32'h0,      C_FTCH, 15, 3, 1);
        vec("async_rst",   0,  0,  0, 0, 0, 0, 32'h0,      C_RST,  0,  0, 0);
        vec("rst_run",     1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 0,  0, 0);
        vec("rst_run2",    1,  0,  1, 0, 0, 0, 32'h0,      C_NORM, 0,  0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
